// File: rtl/dm_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, requester
// port indices and the latched memory-bus request record.
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_M = 2'b01,
        BUSY_A = 2'b10
    } state_t;

    localparam int PORT_M = 0;
    localparam int PORT_A = 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] pc;
    } bus_req_t;

endpackage

// File: rtl/dm_arb_timer.sv
// Access watchdog: armed by start, disarmed by ack, raises expire in the
// TIMEOUT-th busy cycle that passes without an ack.
module dm_arb_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ack,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        expire   = active_q & ~ack & (cnt_q == LAST);
        active_d = active_q;
        cnt_d    = cnt_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (active_q) begin
            if (ack || expire) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-port data memory (M-stage vs aux loader).
// One access in flight, held on the bus until mem_ack or watchdog expiry.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16,
    parameter int CNT_W        = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_be,
    input  logic [31:0] m_pc,
    output logic [31:0] m_rdata,
    output logic        m_done,
    output logic        m_stall,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [3:0]  a_be,
    output logic [31:0] a_rdata,
    output logic        a_done,
    output logic        a_err,
    output logic        m_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_pc,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    bus_req_t         bus_q, bus_d;
    logic [31:0]      m_rdata_q, m_rdata_d;
    logic [31:0]      a_rdata_q, a_rdata_d;

    bus_req_t cand [2];
    logic     grant_m, grant_a, win;
    logic     done_m, done_a, err_m, err_a;
    logic     expire;

    always_comb begin
        cand[PORT_M] = '{we: m_we, addr: m_addr, wdata: m_wdata, be: m_be, pc: m_pc};
        cand[PORT_A] = '{we: a_we, addr: a_addr, wdata: a_wdata, be: a_be, pc: 32'h0};

        state_d   = state_q;
        starve_d  = starve_q;
        bus_d     = bus_q;
        m_rdata_d = m_rdata_q;
        a_rdata_d = a_rdata_q;
        grant_m   = 1'b0;
        grant_a   = 1'b0;
        win       = 1'(PORT_M);
        done_m    = 1'b0;
        done_a    = 1'b0;
        err_m     = 1'b0;
        err_a     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // M wins ties until A has been passed over STARVE_LIMIT times.
                if (m_req && (!a_req || starve_q < STARVE_MAX)) begin
                    grant_m = 1'b1;
                end else if (a_req) begin
                    grant_a = 1'b1;
                end
                win = grant_a ? 1'(PORT_A) : 1'(PORT_M);

                if (grant_m) begin
                    state_d = BUSY_M;
                    bus_d   = cand[win];
                    if (a_req && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (grant_a) begin
                    state_d  = BUSY_A;
                    bus_d    = cand[win];
                    starve_d = '0;
                end
                if (!a_req) begin
                    starve_d = '0;
                end
            end
            BUSY_M: begin
                if (mem_ack) begin
                    done_m  = 1'b1;
                    state_d = IDLE;
                    if (!bus_q.we) begin
                        m_rdata_d = mem_rdata;
                    end
                end else if (expire) begin
                    err_m   = 1'b1;
                    state_d = IDLE;
                end
            end
            BUSY_A: begin
                if (mem_ack) begin
                    done_a  = 1'b1;
                    state_d = IDLE;
                    if (!bus_q.we) begin
                        a_rdata_d = mem_rdata;
                    end
                end else if (expire) begin
                    err_a   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            bus_q     <= '0;
            m_rdata_q <= '0;
            a_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            bus_q     <= bus_d;
            m_rdata_q <= m_rdata_d;
            a_rdata_q <= a_rdata_d;
        end
    end

    dm_arb_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (grant_m | grant_a),
        .ack    (mem_ack),
        .expire (expire)
    );

    // A reset edge abandons the access, so completion pulses are suppressed
    // in the reset cycle even if the memory acks at the same time.
    assign m_done  = done_m & ~reset;
    assign a_done  = done_a & ~reset;
    assign m_err   = err_m & ~reset;
    assign a_err   = err_a & ~reset;
    assign m_stall = m_req & ~m_done & ~m_err & ~reset;

    assign m_rdata   = m_rdata_q;
    assign a_rdata   = a_rdata_q;
    assign mem_req   = (state_q != IDLE);
    assign mem_we    = bus_q.we;
    assign mem_addr  = bus_q.addr;
    assign mem_wdata = bus_q.wdata;
    assign mem_be    = bus_q.be;
    assign mem_pc    = bus_q.pc;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: each task drives one scenario and checks
// the outputs against hand-computed values.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata, m_pc;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;
    logic        m_done, m_stall, m_err;
    logic        a_req, a_we;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_be;
    logic [31:0] a_rdata;
    logic        a_done, a_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_pc;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_be(m_be), .m_pc(m_pc), .m_rdata(m_rdata), .m_done(m_done),
        .m_stall(m_stall),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_be(a_be), .a_rdata(a_rdata), .a_done(a_done), .a_err(a_err),
        .m_err(m_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_pc(mem_pc),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({m_done, m_err, a_done, a_err, m_stall} !== 5'b0) begin
            failures++;
            $display("FAIL reset_pulses got=%b exp=%b", {m_done, m_err, a_done, a_err, m_stall}, 5'b0);
        end
        reset = 1'b0;
        tick();
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_mem_req got=%b exp=%b", mem_req, 1'b0);
        end
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_be, mem_pc} !== 101'b0) begin
            failures++;
            $display("FAIL reset_bus got=%h exp=0", {mem_we, mem_addr, mem_wdata, mem_be, mem_pc});
        end
        checks++;
        if ({m_rdata, a_rdata} !== 64'b0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0", {m_rdata, a_rdata});
        end
    endtask

    task automatic test_m_load;
        tick();
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0010; m_be = 4'hf;
        m_wdata = 32'h0; m_pc = 32'h0000_0400;
        #1;
        checks++;
        if ({m_stall, mem_req} !== 2'b10) begin
            failures++;
            $display("FAIL load_req_cycle stall,mem_req got=%b exp=%b", {m_stall, mem_req}, 2'b10);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_pc} !== {1'b1, 1'b0, 32'h10, 32'h400}) begin
            failures++;
            $display("FAIL load_bus got=%h exp=%h", {mem_req, mem_we, mem_addr, mem_pc}, {1'b1, 1'b0, 32'h10, 32'h400});
        end
        checks++;
        if ({m_done, m_stall} !== 2'b10) begin
            failures++;
            $display("FAIL load_done done,stall got=%b exp=%b", {m_done, m_stall}, 2'b10);
        end
        tick();
        m_req = 1'b0; mem_ack = 1'b0;
        #1;
        checks++;
        if (m_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL load_rdata got=%h exp=%h", m_rdata, 32'hDEAD_BEEF);
        end
        checks++;
        if ({mem_req, m_done} !== 2'b00) begin
            failures++;
            $display("FAIL load_idle mem_req,done got=%b exp=%b", {mem_req, m_done}, 2'b00);
        end
    endtask

    task automatic test_m_store;
        tick();
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0020; m_wdata = 32'h1234_5678;
        m_be = 4'b0011; m_pc = 32'h0000_0408; mem_rdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if (m_stall !== 1'b1) begin
            failures++;
            $display("FAIL store_stall_req got=%b exp=%b", m_stall, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_ack = (i == 2);
            m_req = (i < 3);
            #1;
            checks++;
            if ({mem_we, mem_addr, mem_wdata, mem_be, mem_pc} !==
                {1'b1, 32'h20, 32'h1234_5678, 4'b0011, 32'h408}) begin
                failures++;
                $display("FAIL store_bus_stable cyc=%0d got=%h exp=%h", i,
                         {mem_we, mem_addr, mem_wdata, mem_be, mem_pc},
                         {1'b1, 32'h20, 32'h1234_5678, 4'b0011, 32'h408});
            end
            checks++;
            if ({mem_req, m_stall, m_done} !== {i < 3, i < 2, i == 2}) begin
                failures++;
                $display("FAIL store_ctrl cyc=%0d req,stall,done got=%b exp=%b", i,
                         {mem_req, m_stall, m_done}, {i < 3, i < 2, i == 2});
            end
        end
        mem_ack = 1'b0;
        checks++;
        if (m_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL store_rdata_hold got=%h exp=%h", m_rdata, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_starvation;
        logic got [6];
        logic exp_seq [6];
        int   n;
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        n = 0;
        tick();
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h30; m_pc = 32'h40C; m_be = 4'hf;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h100; a_be = 4'hf;
        mem_ack = 1'b1; mem_rdata = 32'h5A5A_0001;
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++;
            if (m_done && a_done) begin
                failures++;
                $display("FAIL starve_overlap cyc=%0d got=both_done exp=one", i);
            end
            if (m_done || a_done) begin
                if (n < 6) got[n] = a_done;
                n++;
            end
            tick();
        end
        m_req = 1'b0; a_req = 1'b0; mem_ack = 1'b0;
        checks++;
        if (n !== 6) begin
            failures++;
            $display("FAIL starve_count got=%0d exp=%0d", n, 6);
        end
        for (int j = 0; j < 6 && j < n; j++) begin
            checks++;
            if (got[j] !== exp_seq[j]) begin
                failures++;
                $display("FAIL starve_order idx=%0d got_aux=%b exp_aux=%b", j, got[j], exp_seq[j]);
            end
        end
        #1;
        checks++;
        if ({a_rdata, m_rdata} !== {32'h5A5A_0001, 32'h5A5A_0001}) begin
            failures++;
            $display("FAIL starve_rdata got=%h exp=%h", {a_rdata, m_rdata}, {32'h5A5A_0001, 32'h5A5A_0001});
        end
    endtask

    task automatic test_timeout;
        int busy;
        bit seen;
        busy = 0;
        seen = 1'b0;
        tick();
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h44; mem_ack = 1'b0; mem_rdata = 32'h7777_7777;
        #1;
        checks++;
        if (m_stall !== 1'b1) begin
            failures++;
            $display("FAIL tmo_stall_req got=%b exp=%b", m_stall, 1'b1);
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            #1;
            if (mem_req) busy++;
            if (m_err) begin
                seen = 1'b1;
                checks++;
                if ({m_stall, m_done} !== 2'b00) begin
                    failures++;
                    $display("FAIL tmo_err_cycle stall,done got=%b exp=%b", {m_stall, m_done}, 2'b00);
                end
            end
        end
        m_req = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL tmo_err_seen got=0 exp=1");
        end
        checks++;
        if (busy !== 16) begin
            failures++;
            $display("FAIL tmo_busy_cycles got=%0d exp=%0d", busy, 16);
        end
        tick();
        #1;
        checks++;
        if ({mem_req, m_err, m_stall} !== 3'b000) begin
            failures++;
            $display("FAIL tmo_after req,err,stall got=%b exp=%b", {mem_req, m_err, m_stall}, 3'b000);
        end
        checks++;
        if (m_rdata !== 32'h5A5A_0001) begin
            failures++;
            $display("FAIL tmo_rdata_hold got=%h exp=%h", m_rdata, 32'h5A5A_0001);
        end
    endtask

    task automatic test_reset_busy_a;
        tick();
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h200; a_be = 4'hf; a_wdata = 32'h0; mem_ack = 1'b0;
        tick();
        #1;
        checks++;
        if ({mem_req, mem_addr, mem_pc} !== {1'b1, 32'h200, 32'h0}) begin
            failures++;
            $display("FAIL rst_a_bus got=%h exp=%h", {mem_req, mem_addr, mem_pc}, {1'b1, 32'h200, 32'h0});
        end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({a_done, a_err} !== 2'b00) begin
            failures++;
            $display("FAIL rst_a_in_reset done,err got=%b exp=%b", {a_done, a_err}, 2'b00);
        end
        tick();
        reset = 1'b0; a_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        #1;
        checks++;
        if ({a_done, a_err, mem_req, m_stall} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_a_late_ack done,err,req,stall got=%b exp=%b", {a_done, a_err, mem_req, m_stall}, 4'b0000);
        end
        checks++;
        if ({a_rdata, m_rdata, mem_addr, mem_pc} !== 128'b0) begin
            failures++;
            $display("FAIL rst_a_regs got=%h exp=0", {a_rdata, m_rdata, mem_addr, mem_pc});
        end
        mem_ack = 1'b0;
        tick();
        a_req = 1'b1; a_addr = 32'h204;
        tick();
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
        #1;
        checks++;
        if ({a_done, a_err} !== 2'b00) begin
            failures++;
            $display("FAIL rst_ack_same_cycle done,err got=%b exp=%b", {a_done, a_err}, 2'b00);
        end
        tick();
        reset = 1'b0; mem_ack = 1'b0; a_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, a_rdata} !== 33'b0) begin
            failures++;
            $display("FAIL rst_ack_after req,a_rdata got=%h exp=0", {mem_req, a_rdata});
        end
    endtask

    task automatic test_ack_idle;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({m_done, a_done, m_err, a_err, mem_req} !== 5'b0) begin
            failures++;
            $display("FAIL idle_ack_pulses got=%b exp=%b", {m_done, a_done, m_err, a_err, mem_req}, 5'b0);
        end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({mem_req, m_rdata, a_rdata} !== 65'b0) begin
            failures++;
            $display("FAIL idle_ack_state got=%h exp=0", {mem_req, m_rdata, a_rdata});
        end
    endtask

    task automatic test_back_to_back;
        tick();
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h50; m_pc = 32'h500; m_be = 4'hf;
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
        tick();
        #1;
        checks++;
        if ({m_done, mem_addr} !== {1'b1, 32'h50}) begin
            failures++;
            $display("FAIL b2b_first got=%h exp=%h", {m_done, mem_addr}, {1'b1, 32'h50});
        end
        tick();
        m_addr = 32'h54; m_pc = 32'h504; mem_rdata = 32'hAAAA_0002;
        #1;
        checks++;
        if ({m_done, m_stall, m_rdata} !== {1'b0, 1'b1, 32'hAAAA_0001}) begin
            failures++;
            $display("FAIL b2b_gap got=%h exp=%h", {m_done, m_stall, m_rdata}, {1'b0, 1'b1, 32'hAAAA_0001});
        end
        tick();
        #1;
        checks++;
        if ({m_done, mem_addr, mem_pc} !== {1'b1, 32'h54, 32'h504}) begin
            failures++;
            $display("FAIL b2b_second got=%h exp=%h", {m_done, mem_addr, mem_pc}, {1'b1, 32'h54, 32'h504});
        end
        tick();
        m_req = 1'b0; a_req = 1'b1; a_we = 1'b1; a_addr = 32'h60;
        a_wdata = 32'h0F0F_0F0F; a_be = 4'b1000; mem_rdata = 32'hBBBB_BBBB;
        #1;
        checks++;
        if (m_rdata !== 32'hAAAA_0002) begin
            failures++;
            $display("FAIL b2b_rdata got=%h exp=%h", m_rdata, 32'hAAAA_0002);
        end
        tick();
        #1;
        checks++;
        if ({a_done, mem_we, mem_addr, mem_wdata, mem_be, mem_pc} !==
            {1'b1, 1'b1, 32'h60, 32'h0F0F_0F0F, 4'b1000, 32'h0}) begin
            failures++;
            $display("FAIL aux_write got=%h exp=%h",
                     {a_done, mem_we, mem_addr, mem_wdata, mem_be, mem_pc},
                     {1'b1, 1'b1, 32'h60, 32'h0F0F_0F0F, 4'b1000, 32'h0});
        end
        tick();
        a_req = 1'b0; mem_ack = 1'b0;
        #1;
        checks++;
        if (a_rdata !== 32'h0) begin
            failures++;
            $display("FAIL aux_write_rdata_hold got=%h exp=%h", a_rdata, 32'h0);
        end
    endtask

    initial begin
        reset = 1'b1;
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0; m_pc = '0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_m_load();
        test_m_store();
        test_starvation();
        test_timeout();
        test_reset_busy_a();
        test_ack_idle();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters: the M-stage load/store path (port M) and an auxiliary loader/debug port (port A).
- Latches one request at a time and holds it on the memory bus until the memory acknowledges.
- Freezes the pipeline through m_stall while an M-stage access is outstanding.
- Sits between the Memory stage and the DM, replacing the direct M→DM connection.

Parameters:
- STARVE_LIMIT, 4: consecutive M grants allowed while A is waiting before A is forced to win.
- TIMEOUT, 16: cycles in a BUSY state without mem_ack before the access is aborted.
- CNT_W, 5: width of the timeout and starvation counters; must satisfy 2^CNT_W > max(TIMEOUT, STARVE_LIMIT).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- m_req  in  1  M-stage access request; held stable while m_stall=1
- m_we  in  1  M-stage write enable (1=store)
- m_addr  in  32  M-stage byte address (ALU result)
- m_wdata  in  32  M-stage store data (forwarded rt)
- m_be  in  4  M-stage byte enables
- m_pc  in  32  PC of the M-stage instruction, forwarded to DM for store logging
- m_rdata  out  32  last M read data, registered
- m_done  out  1  M access completes this cycle
- m_stall  out  1  freeze F/D/E/M stage registers
- a_req  in  1  aux request; held until a_done or a_err
- a_we  in  1  aux write enable
- a_addr  in  32  aux byte address
- a_wdata  in  32  aux store data
- a_be  in  4  aux byte enables
- a_rdata  out  32  last aux read data, registered
- a_done  out  1  aux access completes this cycle
- a_err  out  1  aux access aborted by timeout
- m_err  out  1  M access aborted by timeout
- mem_req  out  1  DM access strobe
- mem_we  out  1  DM write enable
- mem_addr  out  32  DM address
- mem_wdata  out  32  DM write data
- mem_be  out  4  DM byte enables
- mem_pc  out  32  PC sent to DM (0 for aux accesses)
- mem_ack  in  1  DM completion; read data is valid in the same cycle
- mem_rdata  in  32  DM read data

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; all counters=0; mem_* bus registers=0; m_rdata=0; a_rdata=0. All outputs are 0 during reset and in the first cycle after it.
- States:
  - IDLE: no access outstanding.
  - BUSY_M: M access on the memory bus.
  - BUSY_A: aux access on the memory bus.
- Grant (IDLE only):
  - m_req alone → BUSY_M.
  - a_req alone → BUSY_A.
  - Both asserted → BUSY_M, unless starve_cnt ≥ STARVE_LIMIT, in which case → BUSY_A.
  - On any grant, the winner's we/addr/wdata/be/pc are latched into the mem_* registers.
- Starvation counter:
  - Increments on an M grant made while a_req=1.
  - Clears on any A grant, and whenever a_req=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- mem_req = (state≠IDLE). The latched bus fields stay constant for the whole BUSY period.
- Completion in BUSY_x with mem_ack=1:
  - x_done=1 (combinational).
  - x_rdata←mem_rdata if the access was a read; x_rdata holds otherwise.
  - Next state = IDLE.
- Timeout:
  - tmo_cnt clears on entry to BUSY and increments each BUSY cycle without mem_ack.
  - When tmo_cnt reaches TIMEOUT-1 without an ack: x_err=1 for one cycle, x_rdata holds, next state = IDLE.
  - x_done and x_err are mutually exclusive. If mem_ack arrives in the timeout cycle, it wins (done, not err).
- Stall: m_stall = m_req & ~m_done & ~m_err (combinational).
- Latency: minimum is 2 cycles from request to done. Request seen at cycle t → mem_req rises at t+1 → done at t+1 if DM acks immediately. A new m_req may be presented in the cycle after m_done.
- Boundary conditions:
  - mem_ack in IDLE is ignored.
  - A request that drops in IDLE before being granted is not issued.
  - Aux and M never overlap on the bus.
  - reset in a BUSY state forces IDLE on that edge; mem_req=0 the next cycle; a late ack is ignored.
  - reset and mem_ack in the same cycle: reset wins, and no done is issued.
  - m_req dropping mid-BUSY_M is illegal; the access still completes and m_done is still issued.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'b00, BUSY_M=2'b01, BUSY_A=2'b10;
  - port index constants PORT_M=0, PORT_A=1.
- One sub-module, dm_arb_timer, is natural: it contains the timeout counter plus its compare. Inputs: clk, reset, start, ack. Output: expire.

Test Plan:
- Single M load at addr 0x0000_0010, DM acks 1 cycle after mem_req with rdata 0xDEADBEEF → m_stall=1 for 1 cycle, m_done at t+1, m_rdata=0xDEADBEEF, mem_pc=m_pc.
- M store, we=1, be=4'b0011, wdata 0x1234_5678, ack delayed 3 cycles → mem_* fields stable for 4 cycles, m_stall=1 for 3 cycles, m_rdata unchanged.
- m_req and a_req both held continuously, every access acked in 1 cycle, STARVE_LIMIT=4 → grant sequence M,M,M,M,A,M…; a_done fires on the 5th access.
- mem_ack never asserted, TIMEOUT=16 → m_err pulses exactly 16 cycles after mem_req rises; state returns to IDLE; m_stall drops in the err cycle.
- Reset asserted in the 2nd cycle of BUSY_A, ack arrives the following cycle → no a_done; mem_req=0 after reset; all outputs 0.
- mem_ack pulsed while IDLE with no requests → no done or err; state stays IDLE; rdata registers unchanged.
